dmem_responder: RTL



---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory bus between the MEM stage and dmem_responder,
// plus the IO output and the TX drain port.
interface dmem_responder_if;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;
    logic [15:0] io_out;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output dmemaddr, dmemwdata, dmemwrite, dmemread, tx_ready,
        input  dmemrdata, io_out, tx_data, tx_valid
    );

    modport slave (
        input  dmemaddr, dmemwdata, dmemwrite, dmemread, tx_ready,
        output dmemrdata, io_out, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_responder.sv
// Data RAM plus IO page (output reg, cycle counter, TX FIFO).
// Reads are combinational; every write commits on the clock edge.
module dmem_responder #(
    parameter int RAM_WORDS  = 128,
    parameter int FIFO_DEPTH = 4
) (
    input logic clock,
    input logic reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [15:0] A_IOOUT  = 16'hFFF0;
    localparam logic [15:0] A_CYCLES = 16'hFFF2;
    localparam logic [15:0] A_TXPUSH = 16'hFFF4;
    localparam logic [15:0] A_TXSTAT = 16'hFFF6;

    logic [15:0]   r_ram  [RAM_WORDS];
    logic [15:0]   r_fifo [FIFO_DEPTH];
    logic [15:0]   r_ioout;
    logic [15:0]   r_cycles;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic [15:0]   w_addr;
    logic [AW-1:0] w_idx;
    logic          w_is_ram;
    logic          w_is_io;
    logic          w_is_cyc;
    logic          w_is_push;
    logic          w_is_stat;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_reject;
    logic [15:0]   w_stat;
    logic [15:0]   w_rdata;

    assign w_addr    = bus.dmemaddr & 16'hFFFE;
    assign w_idx     = w_addr[AW:1];
    assign w_is_ram  = {16'h0, w_addr} < 32'(2 * RAM_WORDS);
    assign w_is_io   = w_addr == A_IOOUT;
    assign w_is_cyc  = w_addr == A_CYCLES;
    assign w_is_push = w_addr == A_TXPUSH;
    assign w_is_stat = w_addr == A_TXSTAT;

    assign w_empty = r_count == '0;
    assign w_full  = r_count == CW'(FIFO_DEPTH);
    assign w_pop   = !w_empty && bus.tx_ready;

    // A full FIFO still takes a push when the head leaves the same cycle.
    assign w_push_req = bus.dmemwrite && w_is_push;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_reject   = w_push_req && w_full && !w_pop;

    assign w_stat = {r_ovf, 5'b0, w_full, w_empty, 4'b0, 4'(r_count)};

    always_comb begin
        w_rdata = '0;
        if (bus.dmemread) begin
            unique case (1'b1)
                w_is_ram:  w_rdata = r_ram[w_idx];
                w_is_io:   w_rdata = r_ioout;
                w_is_cyc:  w_rdata = r_cycles;
                w_is_stat: w_rdata = w_stat;
                default:   w_rdata = '0;
            endcase
        end
    end

    assign bus.dmemrdata = w_rdata;
    assign bus.io_out    = r_ioout;
    assign bus.tx_valid  = !w_empty;
    assign bus.tx_data   = w_empty ? 16'h0 : r_fifo[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RAM_WORDS; i++) r_ram[i] <= '0;
        end else if (bus.dmemwrite && w_is_ram) begin
            r_ram[w_idx] <= bus.dmemwdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ioout  <= '0;
            r_cycles <= '0;
        end else begin
            if (bus.dmemwrite && w_is_io) r_ioout <= bus.dmemwdata;
            if (bus.dmemwrite && w_is_cyc) r_cycles <= bus.dmemwdata;
            else r_cycles <= r_cycles + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_push) r_fifo[r_wr_ptr] <= bus.dmemwdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Setting overflow has priority over the clear.
            if (w_reject) r_ovf <= 1'b1;
            else if (bus.dmemwrite && w_is_stat) r_ovf <= 1'b0;
        end
    end
endmodule
